// File: rtl/rate_scheduler_pkg.sv
// Shared definitions for the rate scheduler: state encodings, level codes
// and a small helper used by the sequencing logic.
package rate_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] LVL_025HZ = 2'd0;
  localparam logic [1:0] LVL_05HZ  = 2'd1;
  localparam logic [1:0] LVL_1HZ   = 2'd2;
  localparam logic [1:0] LVL_2HZ   = 2'd3;

  // True when the level is the fastest one, after which the sequence ends.
  function automatic logic is_last_level(input logic [1:0] lvl);
    return (lvl == LVL_2HZ);
  endfunction

endpackage

// File: rtl/rate_edge_sync.sv
// Brings one slow divider output into the clock_50 domain and produces a
// registered single-cycle pulse on each rising edge.
module rate_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise
);

  logic sync1_r;
  logic sync2_r;
  logic dly_r;
  logic rise_r;

  // Two-flop synchroniser, one delay stage and a registered edge pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      dly_r   <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      sync1_r <= async_in;
      sync2_r <= sync1_r;
      dly_r   <= sync2_r;
      rise_r  <= sync2_r & ~dly_r;
    end
  end

  assign rise = rise_r;

endmodule

// File: rtl/rate_scheduler.sv
// Rate scheduler: picks one divider rate per speed level, turns its rising
// edges into single-cycle ticks while running, and steps the level from slow
// to fast every TICKS_PER_LEVEL ticks until the fastest level completes.
module rate_scheduler
  import rate_scheduler_pkg::*;
#(
  parameter int TICKS_PER_LEVEL = 10,
  parameter int CNT_W           = 4,
  parameter int START_LEVEL     = 0
) (
  input  logic             clock_50,
  input  logic             reset,
  input  logic             c025hz,
  input  logic             c05hz,
  input  logic             c1hz,
  input  logic             c2hz,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic             tick,
  output logic [1:0]       level,
  output logic [CNT_W-1:0] tick_count,
  output logic             running,
  output logic             paused,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(TICKS_PER_LEVEL - 1);
  localparam logic [CNT_W-1:0] ZERO_CNT  = CNT_W'(0);
  localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);
  localparam logic [1:0]       START_LVL = 2'(START_LEVEL);

  // All four channels are always synchronised so switching level never
  // presents a stale or spurious edge to the sequencer.
  logic [3:0] rise_vec;
  logic       rise_sel;

  rate_edge_sync u_sync_025 (.clk(clock_50), .reset(reset), .async_in(c025hz), .rise(rise_vec[0]));
  rate_edge_sync u_sync_05  (.clk(clock_50), .reset(reset), .async_in(c05hz),  .rise(rise_vec[1]));
  rate_edge_sync u_sync_1   (.clk(clock_50), .reset(reset), .async_in(c1hz),   .rise(rise_vec[2]));
  rate_edge_sync u_sync_2   (.clk(clock_50), .reset(reset), .async_in(c2hz),   .rise(rise_vec[3]));

  state_t           state_r;
  state_t           state_n;
  logic [1:0]       level_r;
  logic [1:0]       level_n;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_n;
  logic             tick_r;
  logic             tick_n;

  assign rise_sel = rise_vec[level_r];

  // Next-state logic; priority is stop, then start, then pause, then rise.
  always_comb begin
    state_n = state_r;
    level_n = level_r;
    count_n = count_r;
    tick_n  = 1'b0;
    if (stop) begin
      state_n = ST_IDLE;
      level_n = LVL_025HZ;
      count_n = ZERO_CNT;
    end else if (start) begin
      state_n = ST_RUN;
      level_n = START_LVL;
      count_n = ZERO_CNT;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (pause) begin
            // A rise coinciding with pause is deliberately dropped.
            state_n = ST_PAUSE;
          end else if (rise_sel) begin
            tick_n = 1'b1;
            if (count_r == LAST_CNT) begin
              count_n = ZERO_CNT;
              if (is_last_level(level_r)) begin
                state_n = ST_DONE;
              end else begin
                level_n = level_r + 2'd1;
              end
            end else begin
              count_n = count_r + ONE_CNT;
            end
          end else begin
            tick_n = 1'b0;
          end
        end
        ST_PAUSE: begin
          if (pause) begin
            state_n = ST_RUN;
          end else begin
            state_n = ST_PAUSE;
          end
        end
        ST_IDLE: state_n = ST_IDLE;
        ST_DONE: state_n = ST_DONE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // State, level, tick counter and tick output registers.
  always_ff @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      level_r <= LVL_025HZ;
      count_r <= ZERO_CNT;
      tick_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      level_r <= level_n;
      count_r <= count_n;
      tick_r  <= tick_n;
    end
  end

  assign tick       = tick_r;
  assign level      = level_r;
  assign tick_count = count_r;
  assign running    = (state_r == ST_RUN);
  assign paused     = (state_r == ST_PAUSE);
  assign done       = (state_r == ST_DONE);

endmodule

// File: tb/tb_rate_scheduler.sv
// Self-checking bench for rate_scheduler: directed scenarios plus a random
// phase compared against a behavioural model of the sequencing rules.
module tb_rate_scheduler;

  localparam int TPL = 6;
  localparam int CW  = 4;
  localparam int SL  = 1;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic          clock_50 = 1'b0;
  logic          reset    = 1'b1;
  logic [3:0]    rate     = 4'b0000;
  logic          start    = 1'b0;
  logic          pause    = 1'b0;
  logic          stop     = 1'b0;
  logic          tick;
  logic [1:0]    level;
  logic [CW-1:0] tick_count;
  logic          running;
  logic          paused;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock_50 = ~clock_50;

  rate_scheduler #(.TICKS_PER_LEVEL(TPL), .CNT_W(CW), .START_LEVEL(SL)) dut (
    .clock_50(clock_50), .reset(reset),
    .c025hz(rate[0]), .c05hz(rate[1]), .c1hz(rate[2]), .c2hz(rate[3]),
    .start(start), .pause(pause), .stop(stop),
    .tick(tick), .level(level), .tick_count(tick_count),
    .running(running), .paused(paused), .done(done)
  );

  // Behavioural model: an input first sampled high at edge k counts as a
  // rate event at edge k+3; commands are taken at the edge they are present.
  logic [3:0] h1, h2, h3, h4;
  logic [3:0] ev;
  int m_state, m_level, m_count, m_ticks;
  bit m_tick;
  int d_ticks = 0;
  initial m_ticks = 0;

  assign ev = h3 & ~h4;

  // Reference model update on each clock edge, cleared by reset.
  always @(posedge clock_50 or posedge reset) begin
    if (reset) begin
      h1 <= 4'b0; h2 <= 4'b0; h3 <= 4'b0; h4 <= 4'b0;
      m_state <= M_IDLE; m_level <= 0; m_count <= 0; m_tick <= 1'b0;
    end else begin
      h1 <= rate; h2 <= h1; h3 <= h2; h4 <= h3;
      m_tick <= 1'b0;
      if (stop) begin
        m_state <= M_IDLE; m_level <= 0; m_count <= 0;
      end else if (start) begin
        m_state <= M_RUN; m_level <= SL; m_count <= 0;
      end else if (m_state == M_RUN && pause) begin
        m_state <= M_PAUSE;
      end else if (m_state == M_PAUSE && pause) begin
        m_state <= M_RUN;
      end else if (m_state == M_RUN && ev[m_level]) begin
        m_tick  <= 1'b1;
        m_ticks <= m_ticks + 1;
        if (m_count + 1 == TPL) begin
          m_count <= 0;
          if (m_level == 3) m_state <= M_DONE;
          else m_level <= m_level + 1;
        end else begin
          m_count <= m_count + 1;
        end
      end
    end
  end

  // Count DUT tick pulses away from the active edge.
  always @(negedge clock_50) begin
    if (tick === 1'b1) d_ticks <= d_ticks + 1;
  end

  task automatic cmd(input logic s, input logic p, input logic t);
    @(negedge clock_50); start = s; pause = p; stop = t;
    @(negedge clock_50); start = 1'b0; pause = 1'b0; stop = 1'b0;
  endtask

  task automatic pulse(input int ch, input int hi, input int lo);
    @(negedge clock_50); rate[ch] = 1'b1;
    repeat (hi) @(negedge clock_50);
    rate[ch] = 1'b0;
    repeat (lo) @(negedge clock_50);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clock_50);
    n_cmp++; if ({tick, level, tick_count, running, paused, done} !== 10'b0) begin
      n_bad++; $display("FAIL reset_outputs got=%b exp=%b", {tick, level, tick_count, running, paused, done}, 10'b0); end
    reset = 1'b0;
    pulse(0, 4, 3);
    n_cmp++; if (d_ticks !== 0 || running !== 1'b0) begin
      n_bad++; $display("FAIL idle_no_tick got ticks=%0d run=%b exp ticks=0 run=0", d_ticks, running); end
  endtask

  task automatic test_sequence;
    int base, exp_lvl, exp_cnt, total;
    total = (4 - SL) * TPL;
    cmd(1'b1, 1'b0, 1'b0);
    n_cmp++; if (running !== 1'b1 || level !== 2'(SL) || tick_count !== 4'd0) begin
      n_bad++; $display("FAIL start_load got run=%b lvl=%0d cnt=%0d exp run=1 lvl=%0d cnt=0", running, level, tick_count, SL); end
    base = d_ticks;
    pulse(0, 4, 3); pulse(2, 4, 3); pulse(3, 4, 3);
    n_cmp++; if (d_ticks !== base || tick_count !== 4'd0) begin
      n_bad++; $display("FAIL unselected_rate got ticks=%0d cnt=%0d exp ticks=%0d cnt=0", d_ticks, tick_count, base); end
    for (int i = 0; i < total; i++) begin
      pulse(SL + i / TPL, 4, 3);
      exp_lvl = (i + 1 == total) ? 3 : SL + (i + 1) / TPL;
      exp_cnt = (i + 1) % TPL;
      n_cmp++; if (d_ticks !== base + i + 1 || level !== 2'(exp_lvl) || tick_count !== 4'(exp_cnt)) begin
        n_bad++; $display("FAIL seq_step%0d got ticks=%0d lvl=%0d cnt=%0d exp ticks=%0d lvl=%0d cnt=%0d",
                          i, d_ticks - base, level, tick_count, i + 1, exp_lvl, exp_cnt); end
      n_cmp++; if (done !== (i + 1 == total)) begin
        n_bad++; $display("FAIL seq_done%0d got=%b exp=%b", i, done, (i + 1 == total)); end
    end
    pulse(3, 4, 3);
    n_cmp++; if (d_ticks !== base + total || done !== 1'b1 || running !== 1'b0) begin
      n_bad++; $display("FAIL done_hold got ticks=%0d done=%b exp ticks=%0d done=1", d_ticks - base, done, total); end
  endtask

  task automatic test_restart_done;
    cmd(1'b1, 1'b0, 1'b0);
    n_cmp++; if (done !== 1'b0 || running !== 1'b1 || level !== 2'(SL) || tick_count !== 4'd0) begin
      n_bad++; $display("FAIL restart_done got done=%b run=%b lvl=%0d cnt=%0d exp done=0 run=1 lvl=%0d cnt=0",
                        done, running, level, tick_count, SL); end
  endtask

  task automatic test_latency;
    @(negedge clock_50); rate[SL] = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(posedge clock_50); #1;
      n_cmp++; if (tick !== (j == 3)) begin
        n_bad++; $display("FAIL latency_k%0d got=%b exp=%b", j, tick, (j == 3)); end
    end
    @(negedge clock_50); rate[SL] = 1'b0;
    repeat (3) @(negedge clock_50);
    n_cmp++; if (tick_count !== 4'd1) begin
      n_bad++; $display("FAIL latency_count got=%0d exp=1", tick_count); end
  endtask

  task automatic test_pause;
    int base;
    base = d_ticks;
    cmd(1'b0, 1'b1, 1'b0);
    n_cmp++; if (paused !== 1'b1 || running !== 1'b0) begin
      n_bad++; $display("FAIL pause_enter got paused=%b run=%b exp paused=1 run=0", paused, running); end
    repeat (5) pulse(SL, 4, 3);
    n_cmp++; if (d_ticks !== base || tick_count !== 4'd1 || level !== 2'(SL)) begin
      n_bad++; $display("FAIL pause_frozen got ticks=%0d cnt=%0d lvl=%0d exp ticks=%0d cnt=1 lvl=%0d",
                        d_ticks, tick_count, level, base, SL); end
    cmd(1'b0, 1'b1, 1'b0);
    pulse(SL, 4, 3);
    n_cmp++; if (d_ticks !== base + 1 || tick_count !== 4'd2 || running !== 1'b1) begin
      n_bad++; $display("FAIL pause_resume got ticks=%0d cnt=%0d run=%b exp ticks=%0d cnt=2 run=1",
                        d_ticks, tick_count, running, base + 1); end
  endtask

  task automatic test_collision;
    int base;
    base = d_ticks;
    @(negedge clock_50); rate[SL] = 1'b1;
    repeat (3) @(negedge clock_50);
    pause = 1'b1;
    @(negedge clock_50); pause = 1'b0;
    repeat (2) @(negedge clock_50);
    rate[SL] = 1'b0;
    repeat (3) @(negedge clock_50);
    n_cmp++; if (paused !== 1'b1 || d_ticks !== base || tick_count !== 4'd2) begin
      n_bad++; $display("FAIL pause_rise_collide got paused=%b ticks=%0d cnt=%0d exp paused=1 ticks=%0d cnt=2",
                        paused, d_ticks, tick_count, base); end
    cmd(1'b0, 1'b1, 1'b0);
    cmd(1'b1, 1'b0, 1'b1);
    n_cmp++; if ({running, paused, done, level, tick_count} !== 9'b0) begin
      n_bad++; $display("FAIL start_stop_collide got=%b exp=%b", {running, paused, done, level, tick_count}, 9'b0); end
  endtask

  task automatic test_reset_midrun;
    int base;
    cmd(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < TPL + 5; i++) pulse(SL + i / TPL, 4, 3);
    n_cmp++; if (level !== 2'd2 || tick_count !== 4'd5) begin
      n_bad++; $display("FAIL midrun_setup got lvl=%0d cnt=%0d exp lvl=2 cnt=5", level, tick_count); end
    @(negedge clock_50); #2 reset = 1'b1;
    #1;
    n_cmp++; if ({tick, level, tick_count, running, paused, done} !== 10'b0) begin
      n_bad++; $display("FAIL async_reset got=%b exp=%b", {tick, level, tick_count, running, paused, done}, 10'b0); end
    repeat (2) @(negedge clock_50);
    reset = 1'b0;
    base = d_ticks;
    for (int c = 0; c < 4; c++) pulse(c, 4, 3);
    n_cmp++; if (d_ticks !== base || running !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_idle got ticks=%0d run=%b exp ticks=%0d run=0", d_ticks, running, base); end
    cmd(1'b1, 1'b0, 1'b0);
    n_cmp++; if (running !== 1'b1 || level !== 2'(SL)) begin
      n_bad++; $display("FAIL post_reset_start got run=%b lvl=%0d exp run=1 lvl=%0d", running, level, SL); end
  endtask

  task automatic test_random;
    logic [3:0] mask;
    int hi, lo, r, base_d, base_m;
    base_d = d_ticks;
    base_m = m_ticks;
    for (int it = 0; it < 150; it++) begin
      mask = 4'($urandom_range(1, 15));
      hi = $urandom_range(3, 6);
      lo = $urandom_range(2, 5);
      for (int c = 0; c < hi + lo; c++) begin
        @(negedge clock_50);
        n_cmp++; if (tick !== m_tick || level !== 2'(m_level) || tick_count !== 4'(m_count) ||
                     running !== (m_state == M_RUN) || paused !== (m_state == M_PAUSE) || done !== (m_state == M_DONE)) begin
          n_bad++; $display("FAIL random_it%0d got tick=%b lvl=%0d cnt=%0d r/p/d=%b%b%b exp tick=%b lvl=%0d cnt=%0d state=%0d",
                            it, tick, level, tick_count, running, paused, done, m_tick, m_level, m_count, m_state); end
        rate  = (c < hi) ? mask : 4'b0000;
        r     = $urandom_range(0, 99);
        start = (r < 3) || (r == 9);
        pause = (r >= 3) && (r < 8);
        stop  = (r == 8) || (r == 9);
      end
    end
    @(negedge clock_50); start = 1'b0; pause = 1'b0; stop = 1'b0; rate = 4'b0000;
    repeat (6) @(negedge clock_50);
    n_cmp++; if (d_ticks - base_d !== m_ticks - base_m) begin
      n_bad++; $display("FAIL random_tick_total got=%0d exp=%0d", d_ticks - base_d, m_ticks - base_m); end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_restart_done();
    test_latency();
    test_pause();
    test_collision();
    test_reset_midrun();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rate_scheduler.md
Name: rate_scheduler

Overview:
- Sequences the divided-clock outputs of the clock divider (0.25/0.5/1/2 Hz level signals) for the final-project game logic.
- Selects one rate per speed level and converts it to a single-cycle tick in the clock_50 domain.
- Counts ticks and advances the level (slow to fast) after a fixed number of ticks.
- Provides start/pause/stop control and a done indication to the top-level FSM.

Parameters:
- TICKS_PER_LEVEL, 10, ticks spent at each level before advancing (1..2^CNT_W).
- CNT_W, 4, width of tick_count.
- START_LEVEL, 0, level loaded on start (0..3).

Ports:
- clock_50  in  1  50 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- c025hz  in  1  0.25 Hz square wave from the divider; treated as asynchronous.
- c05hz  in  1  0.5 Hz square wave; treated as asynchronous.
- c1hz  in  1  1 Hz square wave; treated as asynchronous.
- c2hz  in  1  2 Hz square wave; treated as asynchronous.
- start  in  1  single-cycle pulse; begin or restart the sequence.
- pause  in  1  single-cycle pulse; toggle RUN/PAUSE.
- stop  in  1  single-cycle pulse; abort to IDLE.
- tick  out  1  single-cycle pulse at the selected rate, asserted only in RUN.
- level  out  2  current speed level: 0=0.25 Hz, 1=0.5 Hz, 2=1 Hz, 3=2 Hz.
- tick_count  out  CNT_W  ticks elapsed at the current level.
- running  out  1  high in RUN.
- paused  out  1  high in PAUSE.
- done  out  1  high in DONE.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, level=0, tick_count=0.
  - tick, running, paused and done all 0.
  - All synchroniser and edge registers cleared.
- Input conditioning:
  - Each of the four rate inputs passes through its own 2-FF synchroniser plus a delay register.
  - rise[i] = sync2[i] & ~dly[i].
  - All four channels run continuously in every state, so a level change never creates a false edge.
- Tick latency:
  - Rate input first sampled high at clock_50 edge k → tick high for the one cycle following edge k+3.
  - The input must stay high for at least 3 cycles.
- tick = registered (rise[level] & state==RUN).
- State machine: IDLE, RUN, PAUSE, DONE.
  - IDLE: start → RUN, with level=START_LEVEL and tick_count=0.
  - RUN, on each qualifying rise:
    - If tick_count == TICKS_PER_LEVEL-1: tick_count=0 and level+1.
    - If that rise occurs at level 3: go to DONE, tick_count=0, level stays 3.
    - Otherwise tick_count+1.
    - The tick for the final rise is still emitted.
  - RUN: pause → PAUSE, and the rise in that same cycle is dropped (no tick, no count).
  - PAUSE: counters and level frozen, no ticks; pause → RUN.
  - DONE: done=1; start → RUN (restart from START_LEVEL); level and tick_count hold.
- Priority within a cycle: stop > start > pause > rise.
  - stop in any state → IDLE, level=0, tick_count=0.
  - start while in RUN or PAUSE → restart: level=START_LEVEL, tick_count=0, RUN.
- Output timing:
  - running, paused and done are decoded from registered state, so there are no combinational paths from inputs to outputs.
  - level and tick_count are registers.
- Width rules:
  - tick_count never exceeds TICKS_PER_LEVEL-1.
  - level never wraps past 3.

Decomposition:
- Shared package (project defines header):
  - State encodings IDLE=0, RUN=1, PAUSE=2, DONE=3.
  - Level constants LVL_025HZ=0 … LVL_2HZ=3.
- One natural sub-module: rate_edge_sync.
  - 2-FF synchroniser plus rising-edge detector for one signal.
  - Instantiated four times.

Test Plan:
- Reset mid-RUN: assert reset asynchronously at level=2, tick_count=5 → outputs 0 and state IDLE immediately; no tick after release until start.
- Basic sequencing:
  - Setup: TICKS_PER_LEVEL=3, START_LEVEL=0, bench drives rate inputs with short periods.
  - Action: start.
  - Expected: 3 ticks at level 0, then 1, 2, 3; the 12th tick asserts done with level=3, tick_count=0.
- Latency: c025hz rises at edge k while in RUN at level 0 → tick high exactly after edge k+3, width 1 cycle; edges on c1hz produce no tick.
- Pause: pause at tick_count=1 → no ticks and counters frozen during 5 c025hz edges; pause again → next edge gives tick_count=2.
- Collisions:
  - pause in the same cycle as rise[level] → tick dropped, PAUSE entered.
  - start and stop in the same cycle → IDLE.
- Restart from DONE: start → RUN, level=START_LEVEL, tick_count=0, done=0 on the next cycle.
